sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO and the next-generation replacement for the fixed 32x16 peripheral FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. Full/empty are exact in the same cycle, with no one-cycle lag from a registered count. Adds fill level, synchronous flush, pass-through write when full, and per-cycle overflow/underflow pulses. Used as the buffering primitive for UART/SPI/I2C TX/RX paths.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_mem_dp.sv | 33 +++
 rtl/sync_fifo_param.sv | 134 +++++++++++++
 tb/tb_sync_fifo_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizes,
// pointer/level width helpers, the level type and the error-pulse bundle.
package fifo_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 16;

   // Pointer width: enough bits to address DEPTH entries (at least one bit).
   function automatic int fifo_ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Level width: one extra bit so the value DEPTH is representable.
   function automatic int fifo_lvl_w(input int depth);
      return fifo_ptr_w(depth) + 1;
   endfunction

   typedef logic [fifo_lvl_w(DEF_DEPTH)-1:0] level_t;

   typedef struct packed {
      logic ovf;
      logic udf;
   } err_pulse_t;

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array with a registered read port. Kept as its own
// block so it can later be swapped for an SRAM macro. Storage is not reset;
// only the read data register is.
module fifo_mem_dp #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store on accepted write.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port: capture the addressed word, hold otherwise. A same-cycle write
   // to the read address is not forwarded; the old word is returned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO. Flags are decoded from the registered level
// so they track it in the same cycle. Flush has priority over read/write.
// Optional build macro SYNC_FIFO_ERR_STICKY_EN adds err_clr and the sticky
// ovf_sticky/udf_sticky error bits.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter  int WIDTH     = DEF_WIDTH,
   parameter  int DEPTH     = DEF_DEPTH,
   parameter  int AF_THRESH = DEPTH - 2,
   parameter  int AE_THRESH = 2,
   localparam int AW        = fifo_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      level,
   output logic             overflow,
   output logic             underflow
`ifdef SYNC_FIFO_ERR_STICKY_EN
   ,
   input  logic             err_clr,
   output logic             ovf_sticky,
   output logic             udf_sticky
`endif
);

   // Reject non power-of-two depths and unreachable almost-full thresholds.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AF_THRESH > DEPTH)
       || (WIDTH < 1)) begin : g_bad_params
      $fatal(1, "sync_fifo_param: illegal parameters");
   end

   localparam int          AE_CLIP  = (AE_THRESH > DEPTH) ? DEPTH : AE_THRESH;
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_CLIP);
   localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_q;
   logic          rd_acc, wr_acc;
   logic          dv_q;
   err_pulse_t    err_q, err_nxt;

   assign empty        = (level_q == '0);
   assign full         = (level_q == LVL_FULL);
   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q <= LVL_AE);
   assign level        = level_q;

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_acc = rd_en & ~empty & ~flush;
   assign wr_acc = wr_en & ~flush & (~full | rd_acc);

   assign err_nxt.ovf = wr_en & ~flush & ~wr_acc;
   assign err_nxt.udf = rd_en & ~flush & ~rd_acc;

   // Pointer and occupancy tracking; flush rewinds everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   // One-cycle status pulses: read-data valid and rejected requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q  <= 1'b0;
         err_q <= '0;
      end else begin
         dv_q  <= rd_acc;
         err_q <= err_nxt;
      end
   end

   assign dout_valid = dv_q;
   assign overflow   = err_q.ovf;
   assign underflow  = err_q.udf;

   fifo_mem_dp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (dout)
   );

`ifdef SYNC_FIFO_ERR_STICKY_EN
   // Sticky error capture; rises with the pulse, a new error beats err_clr,
   // and flush leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         udf_sticky <= 1'b0;
      end else begin
         ovf_sticky <= err_nxt.ovf | (ovf_sticky & ~err_clr);
         udf_sticky <= err_nxt.udf | (udf_sticky & ~err_clr);
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (32x16, AF=14, AE=2): vector table,
// directed corner sequences and a randomized run against a queue model.
module tb_sync_fifo_param;
   import fifo_pkg::*;

   localparam int W  = 32;
   localparam int D  = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout;
   logic         dout_valid, full, empty, almost_full, almost_empty;
   level_t       level;
   logic         overflow, underflow;
   logic         err_clr = 1'b0;
`ifdef SYNC_FIFO_ERR_STICKY_EN
   logic         ovf_sticky, udf_sticky;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout;
   logic         m_dv, m_ovf, m_udf, m_ost, m_ust;

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .overflow(overflow), .underflow(underflow)
`ifdef SYNC_FIFO_ERR_STICKY_EN
      , .err_clr(err_clr), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
`endif
   );

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0; m_ost = 0; m_ust = 0;
   endtask

   // Compare every output against the model
   task automatic chk_all();
      int n;
      n = q.size();
      chk("level", W'(level), W'(n));
      chk("empty", W'(empty), W'(n == 0));
      chk("full", W'(full), W'(n == D));
      chk("almost_full", W'(almost_full), W'(n >= AF));
      chk("almost_empty", W'(almost_empty), W'(n <= AE));
      chk("dout_valid", W'(dout_valid), W'(m_dv));
      chk("dout", dout, m_dout);
      chk("overflow", W'(overflow), W'(m_ovf));
      chk("underflow", W'(underflow), W'(m_udf));
`ifdef SYNC_FIFO_ERR_STICKY_EN
      chk("ovf_sticky", W'(ovf_sticky), W'(m_ost));
      chk("udf_sticky", W'(udf_sticky), W'(m_ust));
`endif
   endtask

   // Drive one cycle, advance the model, compare just after the edge
   task automatic cyc(input logic fl, input logic w, input logic r, input logic [W-1:0] d);
      bit rd_ok, wr_ok;
      flush = fl; wr_en = w; rd_en = r; din = d;
      @(posedge clk);
      rd_ok = r && (q.size() > 0) && !fl;
      wr_ok = w && !fl && ((q.size() < D) || rd_ok);
      if (fl) begin
         q.delete();
         m_dv = 0; m_ovf = 0; m_udf = 0;
      end else begin
         m_dv = rd_ok;
         if (rd_ok) m_dout = q.pop_front();
         if (wr_ok) q.push_back(d);
         m_ovf = w && !wr_ok;
         m_udf = r && !rd_ok;
      end
      m_ost = m_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ost);
      m_ust = m_udf ? 1'b1 : (err_clr ? 1'b0 : m_ust);
      #1;
      chk_all();
      flush = 0; wr_en = 0; rd_en = 0;
   endtask

   task automatic do_reset();
      flush = 0; wr_en = 0; rd_en = 0; err_clr = 0;
      rst_n = 1'b0;
      model_reset();
      #12;
      chk("rst_level", W'(level), '0);
      chk("rst_empty", W'(empty), 1);
      chk("rst_full", W'(full), 0);
      chk("rst_ae", W'(almost_empty), 1);
      chk("rst_af", W'(almost_full), 0);
      chk("rst_dout", dout, '0);
      chk("rst_pulses", W'({dout_valid, overflow, underflow}), '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic         fl, wr, rd;
      logic [W-1:0] din;
      int           lvl;
      logic [W-1:0] dout;
      logic         dv, ovf, udf;
   } vec_t;

   vec_t vec [7];

   initial begin
      // fl wr rd din  | level dout dv ovf udf
      vec[0] = '{0, 1, 1, 32'h55, 1, 32'h00, 0, 0, 1};  // empty + rd + wr
      vec[1] = '{0, 0, 1, 32'h00, 0, 32'h55, 1, 0, 0};
      vec[2] = '{0, 0, 1, 32'h00, 0, 32'h55, 0, 0, 1};  // underflow, dout holds
      vec[3] = '{0, 1, 0, 32'h11, 1, 32'h55, 0, 0, 0};
      vec[4] = '{0, 1, 1, 32'h22, 1, 32'h11, 1, 0, 0};  // level 1: old entry out
      vec[5] = '{1, 1, 1, 32'h33, 0, 32'h11, 0, 0, 0};  // flush wins
      vec[6] = '{0, 0, 0, 32'h00, 0, 32'h11, 0, 0, 0};

      do_reset();

      foreach (vec[i]) begin
         cyc(vec[i].fl, vec[i].wr, vec[i].rd, vec[i].din);
         chk($sformatf("vec%0d_level", i), W'(level), W'(vec[i].lvl));
         chk($sformatf("vec%0d_dout", i), dout, vec[i].dout);
         chk($sformatf("vec%0d_pulses", i), W'({dout_valid, overflow, underflow}),
             W'({vec[i].dv, vec[i].ovf, vec[i].udf}));
      end

      // Fill to full, then one overflow
      do_reset();
      for (int i = 1; i <= D; i++) begin
         cyc(0, 1, 0, W'(i));
         chk("fill_level", W'(level), W'(i));
         chk("fill_af", W'(almost_full), W'(i >= 14));
         chk("fill_full", W'(full), W'(i == 16));
      end
      cyc(0, 1, 0, 32'h99);
      chk("ovf_pulse", W'(overflow), 1);
      chk("ovf_level", W'(level), 16);
      cyc(0, 0, 0, 0);
      chk("ovf_one_cycle", W'(overflow), 0);

      // Drain in order, then underflow
      for (int i = 1; i <= D; i++) begin
         cyc(0, 0, 1, 0);
         chk("drain_dout", dout, W'(i));
         chk("drain_dv", W'(dout_valid), 1);
      end
      chk("drain_empty", W'(empty), 1);
      cyc(0, 0, 1, 0);
      chk("udf_pulse", W'(underflow), 1);
      chk("udf_dout_hold", dout, 32'h10);

      // Pointer wrap
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, W'(32'h300 + i));
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 0, W'(32'hA0 + i));
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 1, 0);
         chk("wrap_dout", dout, W'(32'hA0 + i));
      end

      // Full + rd + wr in one cycle
      for (int i = 1; i <= D; i++) cyc(0, 1, 0, W'(32'h100 + i));
      cyc(0, 1, 1, 32'hDEAD);
      chk("fullrw_ovf", W'(overflow), 0);
      chk("fullrw_level", W'(level), 16);
      chk("fullrw_dout", dout, 32'h101);
      for (int i = 0; i < D; i++) cyc(0, 0, 1, 0);
      chk("fullrw_last", dout, 32'hDEAD);

      // Flush at level 7 with concurrent wr/rd
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, W'(32'h700 + i));
      cyc(0, 0, 1, 0);
      chk("pre_flush_level", W'(level), 7);
      cyc(1, 1, 1, 32'hBAD);
      chk("flush_level", W'(level), 0);
      chk("flush_empty", W'(empty), 1);
      chk("flush_pulses", W'({dout_valid, overflow, underflow}), 0);
      chk("flush_dout", dout, 32'h700);

`ifdef SYNC_FIFO_ERR_STICKY_EN
      for (int i = 0; i <= D; i++) cyc(0, 1, 0, W'(i));
      cyc(1, 0, 0, 0);
      chk("sticky_through_flush", W'(ovf_sticky), 1);
      err_clr = 1'b1;
      cyc(0, 0, 0, 0);
      err_clr = 1'b0;
      chk("sticky_cleared", W'(ovf_sticky), 0);
`endif

      // Reset with a read in flight
      cyc(0, 1, 0, 32'h77);
      cyc(0, 1, 1, 32'h78);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_dv", W'(dout_valid), 0);
      chk("midrst_level", W'(level), 0);
      chk("midrst_dout", dout, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         err_clr = ($urandom_range(0, 99) < 5);
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55,
             $urandom_range(0, 99) < 50, $urandom);
      end
      err_clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
